road_queue_sensor: RTL and testbench

ROAD_QUEUE_SENSOR -- requirements
Module: road_queue_sensor

---
 rtl/road_queue_sensor_if.sv | 53 +++++
 rtl/road_queue_sensor.sv | 142 ++++++++++++++
 tb/tb_road_queue_sensor.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/road_queue_sensor_if.sv
// Signal bundle between the lamp controller side and road_queue_sensor.
//   master : drives arrival pulses, road lamps and walk lamp; observes queue state
//   slave  : road_queue_sensor itself
// With WAIT_STATS_EN defined the bundle also carries max_wait[7:0].
interface road_queue_sensor_if;
  logic       roada_arrive;
  logic       roadb_arrive;
  logic       roadc_arrive;
  logic       roadd_arrive;
  logic [2:0] roada_light;
  logic [2:0] roadb_light;
  logic [2:0] roadc_light;
  logic [2:0] roadd_light;
  logic [2:0] walk_way_light;
  logic [3:0] roada_count;
  logic [3:0] roadb_count;
  logic [3:0] roadc_count;
  logic [3:0] roadd_count;
  logic [3:0] overflow;
  logic       conflict;
  logic [2:0] conflict_code;
`ifdef WAIT_STATS_EN
  logic [7:0] max_wait;

  modport master (
    output roada_arrive, roadb_arrive, roadc_arrive, roadd_arrive,
    output roada_light, roadb_light, roadc_light, roadd_light, walk_way_light,
    input  roada_count, roadb_count, roadc_count, roadd_count,
    input  overflow, conflict, conflict_code, max_wait
  );

  modport slave (
    input  roada_arrive, roadb_arrive, roadc_arrive, roadd_arrive,
    input  roada_light, roadb_light, roadc_light, roadd_light, walk_way_light,
    output roada_count, roadb_count, roadc_count, roadd_count,
    output overflow, conflict, conflict_code, max_wait
  );
`else
  modport master (
    output roada_arrive, roadb_arrive, roadc_arrive, roadd_arrive,
    output roada_light, roadb_light, roadc_light, roadd_light, walk_way_light,
    input  roada_count, roadb_count, roadc_count, roadd_count,
    input  overflow, conflict, conflict_code
  );

  modport slave (
    input  roada_arrive, roadb_arrive, roadc_arrive, roadd_arrive,
    input  roada_light, roadb_light, roadc_light, roadd_light, walk_way_light,
    output roada_count, roadb_count, roadc_count, roadd_count,
    output overflow, conflict, conflict_code
  );
`endif
endinterface

// File: rtl/road_queue_sensor.sv
// road_queue_sensor: per-road vehicle queue estimator and lamp safety monitor.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : road_queue_sensor_if.slave -- arrival pulses, lamp states in;
//          registered queue counts, sticky overflow/conflict/conflict_code out
// Parameter DEPART_CYCLES (1..15): green cycles needed to discharge one vehicle.
// Optional macro WAIT_STATS_EN adds per-road wait counters and bus.max_wait.
module road_queue_sensor #(
  parameter int unsigned DEPART_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  road_queue_sensor_if.slave  bus
);
  localparam int unsigned NR = 4;   // roads
  localparam int unsigned CW = 4;   // count / timer width
  localparam int unsigned WW = 8;   // wait statistic width
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] WALK   = 3'b001;
  localparam logic [2:0] NOWALK = 3'b100;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] TMR_LAST = CW'(DEPART_CYCLES - 1);

  logic [NR-1:0] arrive;
  logic [2:0]    light [NR];

  assign arrive   = {bus.roadd_arrive, bus.roadc_arrive, bus.roadb_arrive, bus.roada_arrive};
  assign light[0] = bus.roada_light;
  assign light[1] = bus.roadb_light;
  assign light[2] = bus.roadc_light;
  assign light[3] = bus.roadd_light;

  logic [CW-1:0] count_q [NR];
  logic [CW-1:0] count_d [NR];
  logic [CW-1:0] timer_q [NR];
  logic [CW-1:0] timer_d [NR];
  logic [NR-1:0] ovf_q, ovf_d;
  logic [NR-1:0] adv, dep;
  logic          conflict_q, conflict_d;
  logic [2:0]    code_q, code_d;
  logic [2:0]    n_active;
  logic          viol_a, viol_b, viol_c;

  // Queue update: a discharge and an arrival in the same cycle cancel out.
  always_comb begin
    ovf_d = ovf_q;
    adv   = '0;
    dep   = '0;
    for (int i = 0; i < NR; i++) begin
      adv[i]     = (light[i] == GREEN) && (count_q[i] != '0);
      dep[i]     = adv[i] && (timer_q[i] == TMR_LAST);
      timer_d[i] = (adv[i] && !dep[i]) ? timer_q[i] + CW'(1) : '0;
      count_d[i] = count_q[i];
      if (arrive[i] && !dep[i]) begin
        if (count_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
        else                       count_d[i] = count_q[i] + CW'(1);
      end else if (!arrive[i] && dep[i]) begin
        count_d[i] = count_q[i] - CW'(1);
      end
    end
  end

  // Safety monitor: first violation latches with priority illegal > walk > multi-green.
  always_comb begin
    n_active = '0;
    viol_c   = (bus.walk_way_light != WALK) && (bus.walk_way_light != NOWALK);
    for (int i = 0; i < NR; i++) begin
      n_active = n_active + 3'(light[i] != RED);
      if ((light[i] != RED) && (light[i] != YELLOW) && (light[i] != GREEN)) viol_c = 1'b1;
    end
    viol_a     = (n_active >= 3'd2);
    viol_b     = (bus.walk_way_light == WALK) && (n_active != '0);
    conflict_d = conflict_q;
    code_d     = code_q;
    if (!conflict_q && (viol_a || viol_b || viol_c)) begin
      conflict_d = 1'b1;
      if (viol_c)      code_d = 3'b100;
      else if (viol_b) code_d = 3'b010;
      else             code_d = 3'b001;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NR; i++) begin
        count_q[i] <= '0;
        timer_q[i] <= '0;
      end
      ovf_q      <= '0;
      conflict_q <= 1'b0;
      code_q     <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        count_q[i] <= count_d[i];
        timer_q[i] <= timer_d[i];
      end
      ovf_q      <= ovf_d;
      conflict_q <= conflict_d;
      code_q     <= code_d;
    end
  end

  assign bus.roada_count   = count_q[0];
  assign bus.roadb_count   = count_q[1];
  assign bus.roadc_count   = count_q[2];
  assign bus.roadd_count   = count_q[3];
  assign bus.overflow      = ovf_q;
  assign bus.conflict      = conflict_q;
  assign bus.conflict_code = code_q;

`ifdef WAIT_STATS_EN
  logic [WW-1:0] wait_q [NR];
  logic [WW-1:0] wait_d [NR];
  logic [WW-1:0] max_q, max_d;

  // Wait counters run while vehicles queue behind a non-green lamp; max tracks next values.
  always_comb begin
    max_d = max_q;
    for (int i = 0; i < NR; i++) begin
      wait_d[i] = '0;
      if ((count_q[i] != '0) && (light[i] != GREEN))
        wait_d[i] = (wait_q[i] == '1) ? wait_q[i] : wait_q[i] + WW'(1);
      if (wait_d[i] > max_d) max_d = wait_d[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NR; i++) wait_q[i] <= '0;
      max_q <= '0;
    end else begin
      for (int i = 0; i < NR; i++) wait_q[i] <= wait_d[i];
      max_q <= max_d;
    end
  end

  assign bus.max_wait = max_q;
`endif
endmodule

// File: tb/tb_road_queue_sensor.sv
// Directed self-checking bench for road_queue_sensor (DEPART_CYCLES = 2).
module tb_road_queue_sensor;
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  road_queue_sensor_if bus();

  road_queue_sensor #(.DEPART_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] req);
    n_total++;
    assert (obs === req) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"},    8'(bus.roada_count), 8'd0);
    chk({tag, "_b"},    8'(bus.roadb_count), 8'd0);
    chk({tag, "_c"},    8'(bus.roadc_count), 8'd0);
    chk({tag, "_d"},    8'(bus.roadd_count), 8'd0);
    chk({tag, "_ovf"},  8'(bus.overflow),    8'd0);
    chk({tag, "_conf"}, 8'(bus.conflict),    8'd0);
    chk({tag, "_code"}, 8'(bus.conflict_code), 8'd0);
  endtask

  task automatic pulse(input int road);
    case (road)
      0: bus.roada_arrive = 1'b1;
      1: bus.roadb_arrive = 1'b1;
      2: bus.roadc_arrive = 1'b1;
      default: bus.roadd_arrive = 1'b1;
    endcase
    tick();
    bus.roada_arrive = 1'b0;
    bus.roadb_arrive = 1'b0;
    bus.roadc_arrive = 1'b0;
    bus.roadd_arrive = 1'b0;
  endtask

  task automatic all_red();
    bus.roada_light    = RED;
    bus.roadb_light    = RED;
    bus.roadc_light    = RED;
    bus.roadd_light    = RED;
    bus.walk_way_light = RED;
  endtask

  initial begin
    logic [3:0] exp_a [6];
    exp_a[0] = 4'd3; exp_a[1] = 4'd2; exp_a[2] = 4'd2;
    exp_a[3] = 4'd1; exp_a[4] = 4'd1; exp_a[5] = 4'd0;

    rst = 1'b0;
    all_red();
    bus.roada_arrive = 1'b1;
    bus.roadb_arrive = 1'b0;
    bus.roadc_arrive = 1'b0;
    bus.roadd_arrive = 1'b0;
    tick();
    // arrival during reset is discarded
    chk_zero("rst");
`ifdef WAIT_STATS_EN
    chk("rst_maxw", bus.max_wait, 8'd0);
`endif
    bus.roada_arrive = 1'b0;
    rst = 1'b1;

    // three arrivals on road A, all red
    for (int i = 0; i < 3; i++) pulse(0);
    chk("arr_a", 8'(bus.roada_count), 8'd3);
    chk("arr_b", 8'(bus.roadb_count), 8'd0);
    chk("arr_c", 8'(bus.roadc_count), 8'd0);
    chk("arr_d", 8'(bus.roadd_count), 8'd0);
    chk("arr_conf", 8'(bus.conflict), 8'd0);

    // discharge road A: one vehicle per two green cycles
    bus.roada_light = GRN;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("dis_a%0d", i), 8'(bus.roada_count), 8'(exp_a[i]));
    end
    chk("dis_tmr", 8'(dut.timer_q[0]), 8'd0);
    tick();
    chk("dis_empty", 8'(bus.roada_count), 8'd0);
    chk("dis_tmr_idle", 8'(dut.timer_q[0]), 8'd0);
    bus.roada_light = RED;

    // yellow holds queue; simultaneous arrival and departure cancel
    pulse(2);
    pulse(2);
    bus.roadc_light = YEL;
    for (int i = 0; i < 4; i++) tick();
    chk("yel_hold", 8'(bus.roadc_count), 8'd2);
    bus.roadc_light = GRN;
    tick();
    pulse(2);
    chk("arr_dep_same", 8'(bus.roadc_count), 8'd2);
    tick();
    tick();
    chk("dis_c", 8'(bus.roadc_count), 8'd1);
    bus.roadc_light = RED;

    // road B saturation
    for (int i = 0; i < 15; i++) pulse(1);
    chk("sat15", 8'(bus.roadb_count), 8'd15);
    chk("sat15_ovf", 8'(bus.overflow), 8'd0);
    pulse(1);
    pulse(1);
    chk("sat17", 8'(bus.roadb_count), 8'd15);
    chk("sat17_ovf", 8'(bus.overflow), 8'b0010);
    chk("pre_conf", 8'(bus.conflict), 8'd0);

    // two greens at once -> code 001; later walk violation ignored
    bus.roada_light = GRN;
    bus.roadc_light = GRN;
    #1;
    chk("conf_lat", 8'(bus.conflict), 8'd0);
    tick();
    all_red();
    chk("conf_a", 8'(bus.conflict), 8'd1);
    chk("conf_a_code", 8'(bus.conflict_code), 8'b001);
    bus.walk_way_light = GRN;
    bus.roadb_light    = GRN;
    tick();
    all_red();
    tick();
    chk("conf_b_sticky", 8'(bus.conflict), 8'd1);
    chk("conf_b_code", 8'(bus.conflict_code), 8'b001);
    chk("b_no_dis", 8'(bus.roadb_count), 8'd15);

    // asynchronous reset mid-cycle
    #2;
    rst = 1'b0;
    #1;
    chk_zero("arst1");
    rst = 1'b1;

    // illegal lamp plus walk -> code 100
    tick();
    bus.roadd_light    = 3'b011;
    bus.walk_way_light = GRN;
    tick();
    all_red();
    chk("conf_c", 8'(bus.conflict), 8'd1);
    chk("conf_c_code", 8'(bus.conflict_code), 8'b100);

    // reset while road A is mid-discharge
    pulse(0);
    bus.roada_light = GRN;
    tick();
    chk("mid_tmr", 8'(dut.timer_q[0]), 8'd1);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("arst2");
    chk("arst2_tmr", 8'(dut.timer_q[0]), 8'd0);
    bus.roada_light = RED;
    rst = 1'b1;
    tick();
    chk("post_rst_a", 8'(bus.roada_count), 8'd0);

`ifdef WAIT_STATS_EN
    // road C waits 40 cycles behind red
    pulse(2);
    for (int i = 0; i < 40; i++) tick();
    chk("maxw40", bus.max_wait, 8'd40);
    bus.roadc_light = GRN;
    for (int i = 0; i < 5; i++) tick();
    chk("maxw_hold", bus.max_wait, 8'd40);
    chk("maxw_c0", 8'(bus.roadc_count), 8'd0);
    bus.roadc_light = RED;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
